// File: rtl/inst_queue_pkg.sv
// Shared constants for the IF->ID instruction queue.
// Mirrors the cpu-wide bus widths and empty-flag encoding.
package inst_queue_pkg;

  localparam int   IQ_DEPTH_LOG2 = 4;
  localparam int   INST_BUS_W    = 32;
  localparam int   ADDR_BUS_W    = 32;

  localparam logic IQ_EMPTY      = 1'b1;
  localparam logic IQ_NOT_EMPTY  = ~IQ_EMPTY;

  localparam logic ENABLE        = 1'b1;
  localparam logic DISABLE       = 1'b0;

  function automatic logic iq_empty_flag(
    input logic is_zero
  );
    return is_zero ? IQ_EMPTY : IQ_NOT_EMPTY;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode/flush signal bundle for the instruction queue.
// master drives push/pop/flush; slave is the queue itself.
interface inst_queue_if #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
);

  logic              IF_valid;
  logic [INST_W-1:0] IF_inst;
  logic [ADDR_W-1:0] IF_pc;
  logic              IF_queue_is_full;

  logic              ID_enable;
  logic              ID_queue_is_empty;
  logic [INST_W-1:0] ID_inst;
  logic [ADDR_W-1:0] ID_pc;

  logic              ROB_clear;

  modport master (
    output IF_valid,
    output IF_inst,
    output IF_pc,
    input  IF_queue_is_full,
    output ID_enable,
    input  ID_queue_is_empty,
    input  ID_inst,
    input  ID_pc,
    output ROB_clear
  );

  modport slave (
    input  IF_valid,
    input  IF_inst,
    input  IF_pc,
    output IF_queue_is_full,
    input  ID_enable,
    output ID_queue_is_empty,
    output ID_inst,
    output ID_pc,
    input  ROB_clear
  );

endinterface

// File: rtl/inst_queue.sv
// Circular IF->ID instruction FIFO with combinational head read.
// Optional IQ_ALMOST_FULL_EN raises full one entry early.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = IQ_DEPTH_LOG2,
  parameter int INST_W     = INST_BUS_W,
  parameter int ADDR_W     = ADDR_BUS_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  inst_queue_if.slave   q
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] L_AFULL = CW'(DEPTH - 1);
  localparam logic [CW-1:0] L_ZERO  = '0;
  localparam logic [CW-1:0] L_ONE   = CW'(1);

  localparam logic [DEPTH_LOG2-1:0] L_PTR1 = DEPTH_LOG2'(1);

  logic [INST_W-1:0]     r_inst_mem [DEPTH];
  logic [ADDR_W-1:0]     r_pc_mem   [DEPTH];

  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [CW-1:0]         r_count;

  logic                  w_is_empty;
  logic                  w_is_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr_en;

  logic [DEPTH_LOG2-1:0] w_head_nx;
  logic [DEPTH_LOG2-1:0] w_tail_nx;
  logic [CW-1:0]         w_count_nx;

  assign w_is_empty = (r_count == L_ZERO);
  assign w_is_full  = (r_count == L_DEPTH);

  // Acceptance always uses the registered count, so a pop never
  // frees a slot for a push in the same cycle.
  assign w_push = q.IF_valid  && !w_is_full;
  assign w_pop  = q.ID_enable && !w_is_empty;

  always_comb begin
    w_head_nx  = r_head;
    w_tail_nx  = r_tail;
    w_count_nx = r_count;
    if (q.ROB_clear) begin
      w_head_nx  = '0;
      w_tail_nx  = '0;
      w_count_nx = '0;
    end else begin
      if (w_push) begin
        w_tail_nx = r_tail + L_PTR1;
      end
      if (w_pop) begin
        w_head_nx = r_head + L_PTR1;
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_nx = r_count + L_ONE;
        2'b01:   w_count_nx = r_count - L_ONE;
        default: w_count_nx = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      r_head  <= w_head_nx;
      r_tail  <= w_tail_nx;
      r_count <= w_count_nx;
    end
  end

  assign w_wr_en = rdy && !rst && !q.ROB_clear && w_push;

  // Storage needs no reset: reads are gated by count.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_inst_mem[r_tail] <= q.IF_inst;
      r_pc_mem[r_tail]   <= q.IF_pc;
    end
  end

  always_comb begin
    q.ID_inst = '0;
    q.ID_pc   = '0;
    if (!w_is_empty) begin
      q.ID_inst = r_inst_mem[r_head];
      q.ID_pc   = r_pc_mem[r_head];
    end
  end

  assign q.ID_queue_is_empty = iq_empty_flag(w_is_empty);

`ifdef IQ_ALMOST_FULL_EN
  // Leaves room for the fetch already in flight when full rises.
  assign q.IF_queue_is_full = (r_count >= L_AFULL);
`else
  assign q.IF_queue_is_full = w_is_full;
`endif

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Circular instruction FIFO between the fetch unit (IF) and the decoder (ID). IF pushes one fetched instruction and its PC per cycle. ID combinationally reads the head entry and pops it by asserting its enable. A ROB misprediction clear empties the queue in one cycle.

Parameters:
DEPTH_LOG2, 4, log2 of entry count (DEPTH = 16)
INST_W, 32, instruction width (matches `InstBus)
ADDR_W, 32, PC width (matches `AddressBus)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rdy  input  1  global ready; when low, all state holds
IF_valid  input  1  push request from fetch
IF_inst  input  INST_W  instruction to push
IF_pc  input  ADDR_W  PC of pushed instruction
IF_queue_is_full  output  1  back-pressure to fetch
ID_enable  input  1  pop request from decoder (same-cycle consume of head)
ID_queue_is_empty  output  1  equals `IQEmpty when count==0
ID_inst  output  INST_W  head instruction
ID_pc  output  ADDR_W  head PC
ROB_clear  input  1  flush on branch misprediction

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high; the clock and reset ports are named clk and rst.
  - All state updates on posedge clk only when rdy=1, except reset.
  - Reset (rst=1 at posedge) sets head=0, tail=0, count=0. Entry contents are don't-care.
  - Reset mid-operation discards all entries. The outputs then read empty=`IQEmpty, full=0, ID_inst=0, ID_pc=0.
- Storage and pointers
  - DEPTH-entry arrays for inst and pc.
  - head and tail are DEPTH_LOG2 bits and wrap naturally modulo DEPTH.
  - count is DEPTH_LOG2+1 bits, range 0..DEPTH.
- Read path (combinational)
  - If count>0: ID_inst=inst_mem[head], ID_pc=pc_mem[head].
  - Otherwise both are 0.
  - ID decodes in the same cycle it pops, so the read path must not be registered: zero-cycle read latency.
- Flags (combinational from registered count)
  - ID_queue_is_empty = (count==0) ? `IQEmpty : !`IQEmpty.
  - IF_queue_is_full = (count==DEPTH).
- Push
  - Accepted when IF_valid=1 and count<DEPTH.
  - Writes mem[tail] and increments tail.
  - A push while count==DEPTH is silently dropped; IF must honour the full flag.
- Pop
  - Accepted when ID_enable=1 and count>0; increments head.
  - A pop while empty is ignored, with no pointer change.
- Simultaneous push and pop
  - Both are accepted when legal; count is unchanged.
  - At count==DEPTH a pop plus push in the same cycle is still rejected for the push, because full is evaluated on registered count.
  - At count==0 the push is accepted and the pop is ignored. There is no bypass: the pushed entry is visible the next cycle.
- ROB_clear
  - Highest priority after rst. Next state is head=0, tail=0, count=0.
  - Any same-cycle push or pop is discarded.
- Latency
  - Push-to-visible at the ID outputs: 1 cycle.
  - Pop takes effect at the next posedge.
- rdy=0
  - Pointers and count hold. Outputs keep reflecting the held state.

Optional Feature:
IQ_ALMOST_FULL_EN
- Defined: IF_queue_is_full asserts when count>=DEPTH-1. This covers fetch's one-cycle in-flight fetch, which may still push once after full asserts. That push is accepted while count==DEPTH-1.
- Not defined: full asserts only at count==DEPTH, and fetch must check full before issuing a memory request.
- Push acceptance (count<DEPTH) is identical in both builds.

Decomposition:
- `IQEmpty, `Enable/`Disable, `InstBus, `AddressBus and `Null stay in cpu_define.v.
- Add `IQDepthLog2 there as the default for DEPTH_LOG2.
- No sub-module: the FIFO is a single flat module, about 130-180 lines.

Test Plan:
- Reset → push 3 (IF_pc 0x0,0x4,0x8; inst 0x00000013) → count=3. ID_pc=0x0 while empty is deasserted. Pop once → next cycle ID_pc=0x4.
- Fill 16 pushes with no pop → full=1 after the 16th (after the 15th with IQ_ALMOST_FULL_EN). A 17th push is dropped, and 16 pops return the PCs in order.
- Wrap-around: fill to 10, pop 8, push 12 → tail has wrapped. Drain sequence matches push order and ends with empty=`IQEmpty.
- Simultaneous push and pop at count=5 for 20 cycles → count stays 5, and ID_pc advances each cycle.
- ROB_clear asserted with IF_valid=1 and ID_enable=1 at count=7 → next cycle count=0, empty asserted, ID_inst=0. The same-cycle push is not stored.
- rdy=0 for 4 cycles with push and pop requests active → state unchanged. rst=1 mid-fill (count=9) → next cycle empty and not full.
